// File: rtl/button_pkg.sv
// Shared definitions for the push-button input path: debounce FSM states and
// default timing constants derived from the 27 MHz board clock.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE            = 2'd0,
      CONFIRM_PRESS   = 2'd1,
      HELD            = 2'd2,
      CONFIRM_RELEASE = 2'd3
   } btn_fsm_e;

   localparam int CLK_HZ              = 27_000_000;
   localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;   // 10 ms
   localparam int DEF_REPEAT_DELAY    = CLK_HZ / 2;     // 0.5 s
   localparam int DEF_REPEAT_PERIOD   = CLK_HZ / 10;    // 0.1 s

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-flop synchroniser, debounce FSM with saturating timer and
// registered press strobe; auto-repeat is built only with BUTTON_AUTO_REPEAT_EN.
module button_debounce
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BUTTON_AUTO_REPEAT_EN
  ,parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY
  ,parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press_pulse,
   output logic btn_state
);

   localparam int             TW    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [TW-1:0]  T_END = TW'(DEBOUNCE_CYCLES);
   localparam logic [TW-1:0]  T_ONE = TW'(1);

   logic [1:0]    sync;
   logic          s;
   btn_fsm_e      state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic          pulse_n;

`ifdef BUTTON_AUTO_REPEAT_EN
   localparam int             RW        = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [RW-1:0]  R_DELAY_M = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0]  R_PER_M   = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rep, rep_n;
   logic          rep_armed, rep_armed_n;   // first repeat already issued
`endif

   assign s         = ~sync[1];
   assign btn_state = (state == HELD) || (state == CONFIRM_RELEASE);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync        <= 2'b11;
         state       <= IDLE;
         timer       <= '0;
         press_pulse <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
         rep         <= '0;
         rep_armed   <= 1'b0;
`endif
      end else begin
         sync        <= {sync[0], btn_n};
         state       <= state_n;
         timer       <= timer_n;
         press_pulse <= pulse_n;
`ifdef BUTTON_AUTO_REPEAT_EN
         rep         <= rep_n;
         rep_armed   <= rep_armed_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      timer_n = timer;
      pulse_n = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_n       = rep;
      rep_armed_n = rep_armed;
`endif
      unique case (state)
         IDLE: begin
            if (s) begin
               state_n = CONFIRM_PRESS;
               timer_n = T_ONE;
            end
         end
         CONFIRM_PRESS: begin
            if (!s) begin
               state_n = IDLE;
               timer_n = '0;
            end else if (timer == T_END) begin
               state_n = HELD;
               timer_n = '0;
               pulse_n = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
               rep_n       = '0;
               rep_armed_n = 1'b0;
`endif
            end else begin
               timer_n = timer + T_ONE;
            end
         end
         HELD: begin
            if (!s) begin
               state_n = CONFIRM_RELEASE;
               timer_n = T_ONE;
            end
`ifdef BUTTON_AUTO_REPEAT_EN
            // Every cycle spent in HELD advances the repeat timer; it is frozen elsewhere.
            if (rep == (rep_armed ? R_PER_M : R_DELAY_M)) begin
               pulse_n     = 1'b1;
               rep_n       = '0;
               rep_armed_n = 1'b1;
            end else begin
               rep_n = rep + RW'(1);
            end
`endif
         end
         CONFIRM_RELEASE: begin
            if (s) begin
               state_n = HELD;
               timer_n = '0;
            end else if (timer == T_END) begin
               state_n = IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer + T_ONE;
            end
         end
         default: begin
            state_n = IDLE;
            timer_n = '0;
         end
      endcase
   end

endmodule

// File: rtl/button_input_counter.sv
// Two debounced push-buttons driving a modulo-2^WIDTH up/down counter for the LEDs.
// Optional auto-repeat while held: define BUTTON_AUTO_REPEAT_EN.
module button_input_counter
   import button_pkg::*;
#(
   parameter int WIDTH           = 6,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       btn_n,
   output logic [1:0]       press_pulse,
   output logic [1:0]       btn_state,
   output logic [WIDTH-1:0] count
);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_timing
      $error("button_input_counter: timing parameters must be >= 1");
   end

   for (genvar i = 0; i < 2; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTO_REPEAT_EN
        ,.REPEAT_DELAY    (REPEAT_DELAY)
        ,.REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_debounce (
         .clk         (clk),
         .rst         (rst),
         .btn_n       (btn_n[i]),
         .press_pulse (press_pulse[i]),
         .btn_state   (btn_state[i])
      );
   end

   // Simultaneous up and down strobes cancel.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         unique case (press_pulse)
            2'b01:   count <= count + WIDTH'(1);
            2'b10:   count <= count - WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_button_input_counter.sv
// Self-checking bench for button_input_counter: directed scenarios plus random
// button activity, compared every cycle against a run-length reference model.
module tb_button_input_counter;

   localparam int W  = 6;
   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   btn_n = 2'b11;
   logic [1:0]   press_pulse;
   logic [1:0]   btn_state;
   logic [W-1:0] count;

   int checks   = 0;
   int failures = 0;

   button_input_counter #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_n       (btn_n),
      .press_pulse (press_pulse),
      .btn_state   (btn_state),
      .count       (count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: the debounced level flips once D+1 consecutive samples of the
   // 2-cycle-delayed pressed level disagree with it; repeats fall at RD + n*RP held cycles.
   logic [1:0] m_d1, m_d2;
   logic [1:0] m_deb, m_pulse;
   int         m_run [2];
   int         m_held[2];
   int         m_count;

   task automatic model_edge(input logic [1:0] b, input logic r);
      logic s;
      logic np;
      if (r) begin
         m_d1 = 2'b11; m_d2 = 2'b11;
         m_deb = 2'b00; m_pulse = 2'b00; m_count = 0;
         for (int i = 0; i < 2; i++) begin m_run[i] = 0; m_held[i] = 0; end
      end else begin
         m_count = (m_count + (1 << W) + int'(m_pulse[0]) - int'(m_pulse[1])) % (1 << W);
         for (int i = 0; i < 2; i++) begin
            s  = ~m_d2[i];
            np = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            if (m_deb[i] && m_run[i] == 0) begin
               m_held[i]++;
               if (m_held[i] >= RD && (m_held[i] - RD) % RP == 0) np = 1'b1;
            end
`endif
            if (s != m_deb[i]) begin
               m_run[i]++;
               if (m_run[i] == D + 1) begin
                  m_deb[i] = s;
                  m_run[i] = 0;
                  if (s) begin np = 1'b1; m_held[i] = 0; end
               end
            end else begin
               m_run[i] = 0;
            end
            m_pulse[i] = np;
         end
         m_d2 = m_d1;
         m_d1 = b;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [1:0] b, input logic r);
      btn_n = b;
      rst   = r;
      @(posedge clk);
      model_edge(b, r);
      #1;
      check("press_pulse", 32'(press_pulse), 32'(m_pulse));
      check("btn_state",   32'(btn_state),   32'(m_deb));
      check("count",       32'(count),       32'(m_count));
   endtask

   // Holds b for n cycles; reports the step of the first pulse and total pulse cycles.
   task automatic hold(input logic [1:0] b, input int n, output int first, output int np);
      first = -1;
      np    = 0;
      for (int j = 1; j <= n; j++) begin
         step(b, 1'b0);
         if (press_pulse != 2'b00) begin
            np++;
            if (first < 0) first = j;
         end
      end
   endtask

   int first, np;
   int seg_len;
   logic [1:0] seg_b;

   initial begin
      // 1. reset
      step(2'b11, 1'b1);
      step(2'b11, 1'b1);
      check("reset_count", 32'(count),       32'd0);
      check("reset_pulse", 32'(press_pulse), 32'd0);
      check("reset_state", 32'(btn_state),   32'd0);
      hold(2'b11, 3, first, np);

      // 2. single press: pulse in the 7th cycle after btn_n falls, count one cycle later
      hold(2'b10, 7, first, np);
      check("press_latency", 32'(first), 32'd7);
      check("state_at_pulse", 32'(btn_state), 32'b01);
      step(2'b10, 1'b0);
      check("count_after_press", 32'(count), 32'd1);
      hold(2'b10, 22, first, np);
      hold(2'b11, 10, first, np);
`ifdef BUTTON_AUTO_REPEAT_EN
      check("count_after_hold", 32'(count), 32'd3);
`else
      check("count_after_hold", 32'(count), 32'd1);
`endif

      // 3. glitch then release bounce
      hold(2'b10, 3, first, np);
      hold(2'b11, 10, first, np);
      check("glitch_pulses", 32'(np), 32'd0);
      hold(2'b10, 10, first, np);
      check("bounce_press_pulses", 32'(np), 32'd1);
      hold(2'b11, 2, first, np);
      hold(2'b10, 8, first, np);
      check("bounce_state_held", 32'(btn_state), 32'b01);
      check("bounce_no_repulse", 32'(np), 32'd0);
      hold(2'b11, 10, first, np);
      check("bounce_released", 32'(btn_state), 32'b00);

      // 4. wrap both ways
      step(2'b11, 1'b1);
      hold(2'b01, 10, first, np);
      hold(2'b11, 10, first, np);
      check("wrap_down", 32'(count), 32'd63);
      hold(2'b10, 10, first, np);
      hold(2'b11, 10, first, np);
      check("wrap_up", 32'(count), 32'd0);

      // 5. simultaneous press
      hold(2'b00, 7, first, np);
      check("both_latency", 32'(first), 32'd7);
      check("both_pulses", 32'(press_pulse), 32'b11);
      hold(2'b00, 3, first, np);
      hold(2'b11, 10, first, np);
      check("both_count", 32'(count), 32'd0);

`ifdef BUTTON_AUTO_REPEAT_EN
      // 6. auto-repeat over 40 held cycles, then reset mid-hold
      hold(2'b10, 47, first, np);
      check("repeat_pulses", 32'(np), 32'd6);
      hold(2'b11, 10, first, np);
      check("repeat_count", 32'(count), 32'd6);
      hold(2'b10, 15, first, np);
      step(2'b10, 1'b1);
      hold(2'b10, 7, first, np);
      check("reset_hold_latency", 32'(first), 32'd7);
      hold(2'b11, 10, first, np);
`endif

      // random activity with occasional resets
      for (int k = 0; k < 300; k++) begin
         seg_b   = 2'($urandom_range(0, 3));
         seg_len = int'($urandom_range(1, 12));
         if ($urandom_range(0, 39) == 0) step(seg_b, 1'b1);
         hold(seg_b, seg_len, first, np);
      end
      hold(2'b11, 12, first, np);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
